tick_counter: RTL and testbench

Parametrised up/down modulo counter advanced by an internal clock-enable prescaler, replacing our divided-clock 4-bit counter. All logic runs on the single system clock; the prescaler produces a one-cycle step strobe instead of a derived clock, so the block is safe for timing closure and partial-reconfiguration regions. Sits between the board clock and LED/display logic, or any consumer needing a slow, loadable count.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/tick_counter_tick_gen.sv | 38 +++
 rtl/tick_counter.sv | 93 +++++++++
 tb/tb_tick_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the tick_counter block: default ratios,
// direction encoding and the prescaler width function.
package counter_pkg;

    localparam int unsigned DEFAULT_DIV = 32'd33554432;
    localparam int unsigned DEFAULT_MOD = 32'd16;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold 0..div-1, never less than one.
    function automatic int unsigned pre_width(input int unsigned div);
        int unsigned w;
        w = 32'd1;
        while ((64'd1 << w) < {32'd0, div}) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_counter_tick_gen.sv
// Clock-enable prescaler: raises step for one cycle every DIV enabled cycles.
// The clr input restarts the period, which is how a load realigns the count phase.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned    PW       = pre_width(DIV);
    localparam logic [PW-1:0]  LAST_VAL = PW'(DIV - 32'd1);
    localparam logic [PW-1:0]  ONE_VAL  = PW'(1'b1);

    logic [PW-1:0] pre_cnt_r;

    assign step = en && (pre_cnt_r == LAST_VAL);

    // Prescaler phase register; clr wins over counting, en=0 holds the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r <= '0;
        end else if (clr) begin
            pre_cnt_r <= '0;
        end else if (step) begin
            pre_cnt_r <= '0;
        end else if (en) begin
            pre_cnt_r <= pre_cnt_r + ONE_VAL;
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

endmodule

// File: rtl/tick_counter.sv
// Loadable up/down modulo counter stepped by a single-clock prescaler strobe.
// Define COUNTER_SAT_EN to saturate at 0 / MOD-1 instead of wrapping.
module tick_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIV   = DEFAULT_DIV,
    parameter int unsigned WIDTH = 32'd4,
    parameter int unsigned MOD   = DEFAULT_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 32'd1);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1'b1);
`ifdef COUNTER_SAT_EN
    localparam logic [WIDTH-1:0] NEAR_MAX = WIDTH'(MOD - 32'd2);
`endif

    logic             step_s;
    logic [WIDTH-1:0] count_r;
    logic             tick_r;
    logic             tc_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tick_nxt_s;
    logic             tc_nxt_s;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step_s)
    );

    // Next count and pulse flags: load beats step, step beats hold.
    always_comb begin
        count_nxt_s = count_r;
        tick_nxt_s  = 1'b0;
        tc_nxt_s    = 1'b0;
        if (load) begin
            count_nxt_s = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step_s) begin
            tick_nxt_s = 1'b1;
            if (dir == DIR_UP) begin
`ifdef COUNTER_SAT_EN
                count_nxt_s = (count_r == MAX_VAL) ? count_r : (count_r + ONE_VAL);
                tc_nxt_s    = (count_r == NEAR_MAX);
`else
                count_nxt_s = (count_r == MAX_VAL) ? '0 : (count_r + ONE_VAL);
                tc_nxt_s    = (count_r == MAX_VAL);
`endif
            end else begin
`ifdef COUNTER_SAT_EN
                count_nxt_s = (count_r == '0) ? count_r : (count_r - ONE_VAL);
                tc_nxt_s    = (count_r == ONE_VAL);
`else
                count_nxt_s = (count_r == '0) ? MAX_VAL : (count_r - ONE_VAL);
                tc_nxt_s    = (count_r == '0);
`endif
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            tick_r  <= 1'b0;
            tc_r    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tick_r  <= tick_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

    assign count_out = count_r;
    assign tick      = tick_r;
    assign tc        = tc_r;

endmodule

// File: tb/tb_tick_counter.sv
// Self-checking bench for tick_counter (DIV=4, WIDTH=4, MOD=10) against a
// behavioural model; the saturating section runs when COUNTER_SAT_EN is defined.
module tb_tick_counter;

    localparam int DIV   = 4;
    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             dir = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count_out;
    logic             tick;
    logic             tc;

    tick_counter #(
        .DIV   (DIV),
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .count_out (count_out),
        .tick      (tick),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model state: enabled cycles into the current period, count, pulses.
    int m_pre   = 0;
    int m_count = 0;
    int m_tick  = 0;
    int m_tc    = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_count"}, int'(count_out), m_count);
        check({tag, "_tick"},  int'(tick),      m_tick);
        check({tag, "_tc"},    int'(tc),        m_tc);
    endtask

    task automatic model_reset();
        m_pre = 0; m_count = 0; m_tick = 0; m_tc = 0;
    endtask

    task automatic cycle(input logic e, input logic d, input logic l, input int lv, input string tag);
        int nxt;
        en = e; dir = d; load = l; load_val = WIDTH'(lv);
        m_tick = 0;
        m_tc   = 0;
        if (l) begin
            m_count = (lv >= MOD) ? MOD - 1 : lv;
            m_pre   = 0;
        end else if (e) begin
            if (m_pre == DIV - 1) begin
                m_pre  = 0;
                m_tick = 1;
`ifdef COUNTER_SAT_EN
                if (d) begin
                    nxt  = m_count + 1;
                    m_tc = (nxt == MOD - 1) ? 1 : 0;
                    m_count = (nxt > MOD - 1) ? MOD - 1 : nxt;
                end else begin
                    nxt  = m_count - 1;
                    m_tc = (nxt == 0) ? 1 : 0;
                    m_count = (nxt < 0) ? 0 : nxt;
                end
`else
                if (d) begin
                    m_tc    = (m_count + 1 == MOD) ? 1 : 0;
                    m_count = (m_count + 1) % MOD;
                end else begin
                    m_tc    = (m_count == 0) ? 1 : 0;
                    m_count = (m_count + MOD - 1) % MOD;
                end
`endif
            end else begin
                m_pre++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset("reset");

        // Count up from reset through the 9 -> 0 wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 0, "up");
        check("first_step_count", int'(count_out), 1);
        check("first_step_tick",  int'(tick), 1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 0, "up");

        // Count down from reset: 0 -> 9 wrap, then 8.
        do_reset("reset_down");
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 0, "down");

        // Mid-period load of 7, then the following full period, then a clamped load.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 0, "pre_load");
        cycle(1'b1, 1'b1, 1'b1, 7, "load7");
        check("load7_value", int'(count_out), 7);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 0, "after_load");
        cycle(1'b0, 1'b1, 1'b1, 12, "load12");
        check("load12_clamp", int'(count_out), 9);

        // Freeze with en=0 for 10 cycles in the middle of a period.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 0, "pre_freeze");
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 0, "freeze");
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 0, "resume");

        // Asynchronous reset in the middle of a period at count 5.
        cycle(1'b1, 1'b1, 1'b1, 5, "load5");
        cycle(1'b1, 1'b1, 1'b0, 0, "mid5");
        do_reset("reset_mid");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 0, "post_reset");
        check("post_reset_count", int'(count_out), 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)), "rand");
        end

`ifdef COUNTER_SAT_EN
        // Saturation: up from 7 reaches 9 with one tc, further steps hold.
        cycle(1'b1, 1'b1, 1'b1, 7, "sat_load");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 0, "sat_up");
        check("sat_hold", int'(count_out), 9);
        for (int i = 0; i < 48; i++) cycle(1'b1, 1'b0, 1'b0, 0, "sat_down");
        check("sat_floor", int'(count_out), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
